// File: rtl/processor_pkg.sv
// Shared fetch-side types and constants for the instruction front end.
package processor_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  localparam logic [XLEN-1:0] BUBBLE_INST      = 32'd0;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // One prefetched instruction with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch storage: DEPTH entries of {pc, inst}, power-of-two depth so the
// pointers wrap naturally. head_c/empty_c give the next-cycle head so the
// owner can register its outputs without adding a cycle of latency.
module fetch_fifo
  import processor_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head_c,
  output logic                     empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic             push_ok, pop_ok;

  // Next pointer/count state; flush wins over any push or pop.
  always_comb begin
    push_ok  = push & ~full & ~flush;
    pop_ok   = pop & ~empty & ~flush;
    rd_ptr_d = rd_ptr + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr + PTR_W'(push_ok);
    count_d  = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    empty_c = (count_d == '0);
    // A push into the slot that becomes the head is the new head.
    head_c  = (push_ok && (wr_ptr == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
  end

  // Pointer, count and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      rd_ptr <= rd_ptr_d;
      wr_ptr <= wr_ptr_d;
      count  <= count_d;
      full   <= (count_d == CNT_W'(DEPTH));
      empty  <= empty_c;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: keeps one fetch outstanding while there is a
// guaranteed free slot, buffers returned words, and flushes on redirect.
module inst_prefetch_queue
  import processor_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ifid_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             push, pop, flush;
  logic             fifo_full, fifo_empty, fifo_empty_c;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     push_entry, head_c;

  // The address register is held stable for the whole WAIT state.
  assign imem_addr = fetch_pc_q;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (push_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head_c  (head_c),
    .empty_c (fifo_empty_c)
  );

  // Next-state, fetch PC and FIFO control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = ifid_ready & ~fifo_empty;
    push_entry = '{pc: fetch_pc_q, inst: imem_rdata};
    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc & ~32'd3;
    end
    case (state_q)
      IDLE: begin
        // In IDLE nothing is outstanding, so count < DEPTH reserves a slot.
        if (!redirect && (fifo_count < CNT_W'(DEPTH))) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_d = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = IDLE;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch state and fetch PC registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Registered request and IF outputs; pc/pc4 hold while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      imem_req <= 1'b0;
      if_valid <= 1'b0;
      if_inst  <= BUBBLE_INST;
      if_pc    <= 32'd0;
      if_pc4   <= 32'd0;
    end else begin
      imem_req <= (state_d == WAIT);
      if_valid <= ~fifo_empty_c;
      if (fifo_empty_c) begin
        if_inst <= BUBBLE_INST;
      end else begin
        if_inst <= head_c.inst;
        if_pc   <= head_c.pc;
        if_pc4  <= head_c.pc + 32'd4;
      end
    end
  end

  // A push must always find a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> !fifo_full);

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue (DEPTH=4, RESET_PC=0).
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int checks = 0;
  int errors = 0;
  int seen   = 0;
  logic [31:0] req_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_pc4[$];
  logic [31:0] pop_inst[$];

  inst_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_ready  (ifid_ready),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    case (a)
      32'h0000_0000: inst_of = 32'h0000_0093;
      32'h0000_0004: inst_of = 32'h0010_0113;
      default:       inst_of = 32'h0700_0013 ^ a;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle per iteration: log a pop, advance, then play memory with fixed latency.
  task automatic run_mem(input int n, input int lat);
    for (int i = 0; i < n; i++) begin
      if (if_valid && ifid_ready) begin
        pop_pc.push_back(if_pc);
        pop_pc4.push_back(if_pc4);
        pop_inst.push_back(if_inst);
      end
      tick();
      if (imem_req) seen++; else seen = 0;
      if (imem_req && seen == 1) req_q.push_back(imem_addr);
      if (imem_req && seen > lat) begin
        imem_ack   = 1'b1;
        imem_rdata = inst_of(imem_addr);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    ifid_ready  = 1'b0;
    tick();
    tick();
    req_q.delete();
    pop_pc.delete();
    pop_pc4.delete();
    pop_inst.delete();
    seen = 0;
    rst  = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", if_inst); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", if_pc); end
    checks++; if (if_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected 00000000", if_pc4); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    ifid_ready = 1'b1;
    run_mem(2, 1);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %b expected 0", if_valid); end
    run_mem(1, 1);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h expected 00000000", if_pc); end
    checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL basic_pc4: got %h expected 00000004", if_pc4); end
    checks++; if (if_inst !== 32'h0000_0093) begin errors++; $display("FAIL basic_inst: got %h expected 00000093", if_inst); end
    run_mem(1, 1);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b expected 0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL empty_bubble: got %h expected 00000000", if_inst); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL empty_pc_hold: got %h expected 00000000", if_pc); end
    checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL empty_pc4_hold: got %h expected 00000004", if_pc4); end
    run_mem(10, 1);
    checks++;
    if (req_q.size() < 2 || pop_pc.size() < 2) begin
      errors++; $display("FAIL basic_counts: got req=%0d pop=%0d expected >=2 each", req_q.size(), pop_pc.size());
    end else begin
      checks++; if (req_q[0] !== 32'h0) begin errors++; $display("FAIL basic_req0: got %h expected 00000000", req_q[0]); end
      checks++; if (req_q[1] !== 32'h4) begin errors++; $display("FAIL basic_req1: got %h expected 00000004", req_q[1]); end
      checks++; if (pop_pc[1] !== 32'h4) begin errors++; $display("FAIL basic_pop1_pc: got %h expected 00000004", pop_pc[1]); end
      checks++; if (pop_inst[1] !== 32'h0010_0113) begin errors++; $display("FAIL basic_pop1_inst: got %h expected 00100113", pop_inst[1]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    run_mem(40, 1);
    checks++; if (req_q.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", req_q.size()); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_idle: got %b expected 0", imem_req); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=00000000", if_valid, if_pc); end
    ifid_ready = 1'b1;
    run_mem(1, 1);
    ifid_ready = 1'b0;
    run_mem(20, 1);
    checks++;
    if (req_q.size() != 5) begin
      errors++; $display("FAIL bp_one_more: got %0d requests expected 5", req_q.size());
    end else begin
      checks++; if (req_q[4] !== 32'h10) begin errors++; $display("FAIL bp_req4_addr: got %h expected 00000010", req_q[4]); end
    end
    checks++; if (pop_pc.size() != 1) begin errors++; $display("FAIL bp_pop_count: got %0d expected 1", pop_pc.size()); end
    checks++; if (if_pc !== 32'h4 || if_inst !== 32'h0010_0113) begin errors++; $display("FAIL bp_new_head: got pc=%h inst=%h expected 00000004/00100113", if_pc, if_inst); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full: got %b expected 0", imem_req); end
  endtask

  task automatic test_redirect_idle();
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ridle_no_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ridle_align: got %h expected fffffffc", imem_addr); end
    run_mem(10, 1);
    checks++;
    if (req_q.size() < 2) begin
      errors++; $display("FAIL ridle_req_count: got %0d expected >=2", req_q.size());
    end else begin
      checks++; if (req_q[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ridle_req0: got %h expected fffffffc", req_q[0]); end
      checks++; if (req_q[1] !== 32'h0) begin errors++; $display("FAIL ridle_pc_wrap: got %h expected 00000000", req_q[1]); end
    end
    checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0) begin errors++; $display("FAIL ridle_head: got pc=%h pc4=%h expected fffffffc/00000000", if_pc, if_pc4); end
    checks++; if (if_inst !== 32'hF8FF_FFEF) begin errors++; $display("FAIL ridle_inst: got %h expected f8ffffef", if_inst); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rwait_req: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rwait_drop_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rwait_new_pc: got %h expected 00000100", imem_addr); end
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rwait_drop_hold: got %b expected 0", imem_req); end
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rwait_stale: got req=%b valid=%b expected 0/0", imem_req, if_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rwait_refetch: got req=%b addr=%h expected 1/00000100", imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL rwait_pending: got valid=%b req=%b expected 0/1", if_valid, imem_req); end
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0513;
    tick();
    imem_ack = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_pc4 !== 32'h104) begin errors++; $display("FAIL rwait_head: got v=%b pc=%h pc4=%h expected 1/00000100/00000104", if_valid, if_pc, if_pc4); end
    checks++; if (if_inst !== 32'h0000_0513) begin errors++; $display("FAIL rwait_inst: got %h expected 00000513", if_inst); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    run_mem(7, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL rap_setup: got req=%b addr=%h expected 1/00000008", imem_req, imem_addr); end
    imem_ack    = 1'b1;
    imem_rdata  = 32'h1234_5678;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    ifid_ready  = 1'b1;
    tick();
    imem_ack   = 1'b0;
    redirect   = 1'b0;
    ifid_ready = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL rap_flushed: got v=%b inst=%h expected 0/00000000", if_valid, if_inst); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rap_idle: got %b expected 0", imem_req); end
    checks++; if (if_pc !== 32'h0 || if_pc4 !== 32'h4) begin errors++; $display("FAIL rap_pc_hold: got %h/%h expected 00000000/00000004", if_pc, if_pc4); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rap_refetch: got req=%b addr=%h expected 1/00000200", imem_req, imem_addr); end
    seen = 1;
    run_mem(2, 1);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL rap_no_push: got v=%b pc=%h expected 1/00000200", if_valid, if_pc); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ifid_ready = 1'b1;
    run_mem(7, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL rmw_setup: got req=%b addr=%h expected 1/00000008", imem_req, imem_addr); end
    rst = 1'b0;
    tick();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0000;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmw_in_reset: got req=%b v=%b expected 0/0", imem_req, if_valid); end
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmw_refetch: got req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rmw_ack_dropped: got %b expected 0", if_valid); end
    seen = 1;
    run_mem(2, 1);
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0000_0093) begin errors++; $display("FAIL rmw_head: got v=%b pc=%h inst=%h expected 1/00000000/00000093", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_wrap();
    int k;
    do_reset();
    run_mem(15, 1);
    k = 0;
    while (pop_pc.size() < 20 && k < 400) begin
      ifid_ready = ((k % 7) < 4);
      run_mem(1, 1);
      k++;
    end
    checks++;
    if (pop_pc.size() < 20 || req_q.size() < 20) begin
      errors++; $display("FAIL wrap_timeout: got pops=%0d reqs=%0d expected >=20 each", pop_pc.size(), req_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++; if (req_q[i] !== 32'(4 * i)) begin errors++; $display("FAIL wrap_req[%0d]: got %h expected %h", i, req_q[i], 32'(4 * i)); end
        checks++; if (pop_pc[i] !== 32'(4 * i)) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, pop_pc[i], 32'(4 * i)); end
        checks++; if (pop_pc4[i] !== 32'(4 * i + 4)) begin errors++; $display("FAIL wrap_pc4[%0d]: got %h expected %h", i, pop_pc4[i], 32'(4 * i + 4)); end
        checks++; if (pop_inst[i] !== inst_of(32'(4 * i))) begin errors++; $display("FAIL wrap_inst[%0d]: got %h expected %h", i, pop_inst[i], inst_of(32'(4 * i))); end
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    ifid_ready  = 1'b0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_reset_mid_wait();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the prefetch FIFO entry count; it SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port imem_req, output, 1 bit: fetch request to the instruction memory.
REQ-006 Port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 Port imem_ack, input, 1 bit: response valid, arriving at least 1 cycle after the request.
REQ-008 Port imem_rdata, input, 32 bits: instruction word, qualified by imem_ack.
REQ-009 Port redirect, input, 1 bit: branch or jump taken; flush the queue and refetch.
REQ-010 Port redirect_pc, input, 32 bits: target address, qualified by redirect.
REQ-011 Port ifid_ready, input, 1 bit: the IF/ID stage accepts this cycle (PCWrite and IFIDWrite asserted).
REQ-012 Port if_valid, output, 1 bit: the queue head holds a valid instruction.
REQ-013 Port if_inst, output, 32 bits: head instruction; 32'd0 (bubble) when if_valid=0.
REQ-014 Port if_pc, output, 32 bits: head PC.
REQ-015 Port if_pc4, output, 32 bits: head PC+4, feeding the IF/ID {pc4, pc, inst} fields.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and DROP.
REQ-017 In IDLE, the block SHALL assert imem_req with imem_addr=fetch_pc when count<DEPTH and redirect=0, then move to WAIT; only one request may be outstanding.
REQ-018 In WAIT, imem_req and imem_addr SHALL stay stable until imem_ack.
- On imem_ack: push {fetch_pc, imem_rdata}, set fetch_pc+=4 (mod 2^32), return to IDLE.
REQ-019 A push SHALL never overflow, because a request is issued only when a free slot is guaranteed, counting the outstanding request.
REQ-020 Push-to-visible latency SHALL be 1 cycle: a word acked in cycle N appears at the head in N+1 at the earliest; there is no combinational bypass.
REQ-021 A pop SHALL occur when if_valid and ifid_ready are both 1; push and pop in the same cycle SHALL leave count unchanged.
REQ-022 On redirect, the block SHALL, in the next cycle, clear the FIFO (count=0, both pointers 0) and set fetch_pc={redirect_pc[31:2],2'b00}.
REQ-023 Redirect handling by state:
- WAIT without imem_ack: go to DROP.
- WAIT with imem_ack in the same cycle: discard the data and go to IDLE.
- IDLE: no request is issued that cycle.
REQ-024 In DROP, imem_req SHALL be 0; the next imem_ack SHALL be discarded, then the FSM goes to IDLE.
- A further redirect in DROP only updates fetch_pc.
REQ-025 Redirect SHALL take priority over a simultaneous pop and push: the popped entry is lost, and the IF/ID flush covers it.
REQ-026 FIFO read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-027 When the queue is empty, the block SHALL drive if_valid=0, if_inst=32'd0, and if_pc and if_pc4 at their last values.

Reset
REQ-028 When rst=0 at a clock edge, the block SHALL enter IDLE with fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0 and if_valid=0.
- if_inst, if_pc and if_pc4 SHALL all be 0.
REQ-029 When reset is asserted during WAIT, the outstanding response SHALL be ignored: an imem_ack in the first post-reset cycle with no request issued SHALL be dropped.

Structure
REQ-030 The shared package processor_pkg SHALL hold:
- the BUBBLE_INST constant (32'd0);
- the DEFAULT_RESET_PC constant;
- the fetch-state enum {IDLE, WAIT, DROP}.
REQ-031 The FIFO storage SHALL be a single sub-module, fetch_fifo, of width 64 (pc, inst) with DEPTH entries; it exposes push, pop, flush, full, empty and count.

Verification
REQ-032 After reset release, with 1-cycle ack returning 32'h0000_0093 and 32'h0010_0113 and ifid_ready=1:
- the first request uses addr 0x0, and the first if_valid shows pc=0x0, pc4=0x4, inst=32'h0000_0093;
- the second word appears at pc=0x4.
REQ-033 With ifid_ready=0 and DEPTH=4: exactly 4 requests are issued, then imem_req stays 0; raising ifid_ready for 1 cycle allows exactly 1 new request.
REQ-034 Redirect to 0x0000_0102 during WAIT with a 3-cycle ack:
- the stale ack is dropped;
- the next request uses addr 0x0000_0100;
- if_valid stays 0 until that word returns.
REQ-035 Redirect, imem_ack and pop in the same cycle with count=2: next cycle count=0, FSM in IDLE, no data pushed.
REQ-036 rst=0 asserted mid-WAIT for 1 cycle, with ack arriving on the first cycle after release: the ack is ignored, and the next request uses RESET_PC.
REQ-037 Over 20 sequential fetches with DEPTH=4: pointers wrap correctly, and the PC sequence is strictly +4 with no loss or duplication.
